// File: rtl/l1_cache.sv
// l1_cache: direct-mapped, write-back, write-allocate L1 cache with one
// 128-bit line per set. Hits complete with zero wait states. Misses run a
// WRITEBACK of a dirty victim if there is one, then a FILL, through a
// wishbone master port to backing memory.
module l1_cache #(
  parameter int IDX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst,

  // Pipeline side (wishbone slave)
  input  logic [11:0]  cpu_adr,
  input  logic [127:0] cpu_dat_m,
  input  logic [15:0]  cpu_sel,
  input  logic         cpu_we,
  input  logic         cpu_stb,
  input  logic         cpu_cyc,
  output logic [127:0] cpu_dat_s,
  output logic         cpu_ack,

  // Backing memory side (wishbone master)
  output logic [11:0]  mem_adr,
  output logic [127:0] mem_dat_m,
  output logic [15:0]  mem_sel,
  output logic         mem_we,
  output logic         mem_stb,
  output logic         mem_cyc,
  input  logic [127:0] mem_dat_s,
  input  logic         mem_ack
);

  localparam int SETS  = 1 << IDX_BITS;
  localparam int TAG_W = 12 - IDX_BITS;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;

  // ---------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       state_next;

  logic [SETS-1:0]  valid;
  logic [SETS-1:0]  dirty;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [127:0]     line_mem [SETS];

  // Address of the miss being serviced. Captured when the miss is detected
  // so the memory-side address and the refill target stay fixed even if the
  // pipeline drops or changes its request while the miss is in flight.
  logic [11:0]      miss_adr;

  // ---------------------------------------------------------------------
  // Address decode and hit detection
  // ---------------------------------------------------------------------
  logic [IDX_BITS-1:0] idx;
  logic [TAG_W-1:0]    cpu_tag;
  logic [IDX_BITS-1:0] miss_idx;
  logic [TAG_W-1:0]    miss_tag;

  assign idx      = cpu_adr[IDX_BITS-1:0];
  assign cpu_tag  = cpu_adr[11:IDX_BITS];
  assign miss_idx = miss_adr[IDX_BITS-1:0];
  assign miss_tag = miss_adr[11:IDX_BITS];

  logic req_active;
  logic tag_match;
  logic hit;
  logic miss;
  logic write_hit;
  logic set_dirty;
  logic wb_done;
  logic fill_done;

  assign req_active = cpu_stb & cpu_cyc;
  assign tag_match  = (tag_mem[idx] == cpu_tag);

  // Hits are only recognised in IDLE; tag/data contents of an invalid set
  // are never trusted because valid gates the match.
  assign hit        = (state == S_IDLE) & req_active & valid[idx] & tag_match;
  assign miss       = (state == S_IDLE) & req_active & ~hit;
  assign write_hit  = hit & cpu_we;
  assign set_dirty  = write_hit & (|cpu_sel);

  // Memory completions only count in the state that issued the cycle; a
  // stray mem_ack in IDLE has no effect. Gating with rst keeps an edge that
  // coincides with reset from committing a refill.
  assign wb_done    = (state == S_WRITEBACK) & mem_ack & ~rst;
  assign fill_done  = (state == S_FILL) & mem_ack & ~rst;

  // ---------------------------------------------------------------------
  // Pipeline-side outputs
  // ---------------------------------------------------------------------
  // Zero-wait hit: ack is a pure function of the current request and the
  // stored tag/valid state.
  assign cpu_ack   = hit & ~rst;

  // Read data always comes from the indexed line; on a miss it is a
  // don't-care but is still driven from storage rather than left floating.
  assign cpu_dat_s = line_mem[idx];

  // ---------------------------------------------------------------------
  // Byte-merge of a write hit into the stored line
  // ---------------------------------------------------------------------
  logic [127:0] merged_line;

  // Combine the stored line with the enabled bytes of the write data.
  always_comb begin
    // NOTE: assign every combinational output a default before any
    // conditional update, otherwise the tool infers a latch.
    merged_line = line_mem[idx];
    for (int b = 0; b < 16; b++) begin
      if (cpu_sel[b]) begin
        merged_line[8*b +: 8] = cpu_dat_m[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Miss-handling FSM
  // ---------------------------------------------------------------------
  // Next-state selection: a miss goes to WRITEBACK only when the victim
  // holds modified data; each memory phase advances on its own mem_ack.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (miss) begin
          state_next = (valid[idx] & dirty[idx]) ? S_WRITEBACK : S_FILL;
        end
      end
      S_WRITEBACK: begin
        if (wb_done) begin
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state: FSM, per-set valid/dirty flags and the captured miss
  // address. Reset clears all flags so every set reads as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_adr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state <= state_next;
      if (miss) begin
        miss_adr <= cpu_adr;
      end
      if (set_dirty) begin
        dirty[idx] <= 1'b1;
      end
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage: refilled on FILL completion, byte-merged on a
  // write hit. The two never coincide since hits only occur in IDLE.
  always_ff @(posedge clk) begin
    // NOTE: tag and line arrays have no reset; valid=0 makes their contents
    // irrelevant, and leaving them unreset lets them map onto RAM.
    if (fill_done) begin
      line_mem[miss_idx] <= mem_dat_s;
      tag_mem[miss_idx]  <= miss_tag;
    end else if (write_hit) begin
      line_mem[idx] <= merged_line;
    end
  end

  // ---------------------------------------------------------------------
  // Memory-side outputs
  // ---------------------------------------------------------------------
  // Drive the wishbone master purely from state and captured miss address,
  // so every output holds steady until mem_ack ends the phase.
  always_comb begin
    mem_adr   = miss_adr;
    mem_dat_m = '0;
    mem_sel   = '0;
    mem_we    = 1'b0;
    mem_stb   = 1'b0;
    mem_cyc   = 1'b0;
    case (state)
      S_WRITEBACK: begin
        mem_adr   = {tag_mem[miss_idx], miss_idx};
        mem_dat_m = line_mem[miss_idx];
        mem_sel   = 16'hFFFF;
        mem_we    = 1'b1;
        mem_stb   = 1'b1;
        mem_cyc   = 1'b1;
      end
      S_FILL: begin
        mem_adr   = miss_adr;
        mem_sel   = 16'hFFFF;
        mem_stb   = 1'b1;
        mem_cyc   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l1_cache.sv
// tb_l1_cache: directed self-checking bench for l1_cache (IDX_BITS = 3).
// Acts as both pipeline and backing memory; every expected value below is
// written out by hand from the intended cache behaviour.
module tb_l1_cache;

  logic         clk;
  logic         rst;
  logic [11:0]  cpu_adr;
  logic [127:0] cpu_dat_m;
  logic [15:0]  cpu_sel;
  logic         cpu_we;
  logic         cpu_stb;
  logic         cpu_cyc;
  logic [127:0] cpu_dat_s;
  logic         cpu_ack;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_m;
  logic [15:0]  mem_sel;
  logic         mem_we;
  logic         mem_stb;
  logic         mem_cyc;
  logic [127:0] mem_dat_s;
  logic         mem_ack;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] LINE_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] LINE_B = 128'hA5A5A5A5_5A5A5A5A_DEADBEEF_01234567;
  localparam logic [127:0] LINE_C = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] LINE_D = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
  localparam logic [127:0] JUNK   = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

  l1_cache #(.IDX_BITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_adr   (cpu_adr),
    .cpu_dat_m (cpu_dat_m),
    .cpu_sel   (cpu_sel),
    .cpu_we    (cpu_we),
    .cpu_stb   (cpu_stb),
    .cpu_cyc   (cpu_cyc),
    .cpu_dat_s (cpu_dat_s),
    .cpu_ack   (cpu_ack),
    .mem_adr   (mem_adr),
    .mem_dat_m (mem_dat_m),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .mem_stb   (mem_stb),
    .mem_cyc   (mem_cyc),
    .mem_dat_s (mem_dat_s),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the sequence is fixed-length, but never allow a hang.
  initial begin
    #200000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled on the falling edge.
  task automatic settle();
    @(negedge clk);
  endtask

  // Memory-side checks shared by several steps.
  task automatic check_fill(input string tag, input logic [11:0] adr);
    check({tag, "_stb"}, mem_stb, 1'b1);
    check({tag, "_cyc"}, mem_cyc, 1'b1);
    check({tag, "_we"},  mem_we,  1'b0);
    check({tag, "_sel"}, mem_sel, 16'hFFFF);
    check({tag, "_adr"}, mem_adr, adr);
    check({tag, "_ack"}, cpu_ack, 1'b0);
  endtask

  task automatic check_wb(input string tag, input logic [11:0] adr,
                          input logic [127:0] dat);
    check({tag, "_stb"}, mem_stb,   1'b1);
    check({tag, "_cyc"}, mem_cyc,   1'b1);
    check({tag, "_we"},  mem_we,    1'b1);
    check({tag, "_sel"}, mem_sel,   16'hFFFF);
    check({tag, "_adr"}, mem_adr,   adr);
    check({tag, "_dat"}, mem_dat_m, dat);
    check({tag, "_ack"}, cpu_ack,   1'b0);
  endtask

  initial begin
    logic [127:0] line_a_mod;
    logic [127:0] wr_data;

    line_a_mod        = LINE_A;
    line_a_mod[15:0]  = 16'hBEEF;
    wr_data           = '0;
    wr_data[15:0]     = 16'hBEEF;

    rst       = 1'b1;
    cpu_adr   = '0;
    cpu_dat_m = '0;
    cpu_sel   = '0;
    cpu_we    = 1'b0;
    cpu_stb   = 1'b0;
    cpu_cyc   = 1'b0;
    mem_dat_s = '0;
    mem_ack   = 1'b0;

    // ---- Reset state ----
    next();
    settle();
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_mem_stb", mem_stb, 1'b0);
    check("rst_mem_cyc", mem_cyc, 1'b0);
    check("rst_mem_we",  mem_we,  1'b0);
    next();
    rst = 1'b0;

    // ---- Clean read miss of 0x010, memory answers on 3rd FILL cycle ----
    cpu_adr = 12'h010;
    cpu_stb = 1'b1;
    cpu_cyc = 1'b1;
    settle();
    check("miss0_ack", cpu_ack, 1'b0);
    check("miss0_idle_stb", mem_stb, 1'b0);
    next();
    settle();
    check_fill("fill0_c1", 12'h010);
    next();
    settle();
    check_fill("fill0_c2", 12'h010);
    next();
    mem_ack   = 1'b1;
    mem_dat_s = LINE_A;
    settle();
    check_fill("fill0_c3", 12'h010);
    next();
    mem_ack   = 1'b0;
    mem_dat_s = JUNK;
    settle();
    check("hit0_ack", cpu_ack, 1'b1);
    check("hit0_dat", cpu_dat_s, LINE_A);
    check("hit0_stb", mem_stb, 1'b0);

    // ---- Second back-to-back read hit ----
    next();
    settle();
    check("hit1_ack", cpu_ack, 1'b1);
    check("hit1_dat", cpu_dat_s, LINE_A);
    check("hit1_stb", mem_stb, 1'b0);

    // ---- Write hit, bytes 0-1 ----
    next();
    cpu_we    = 1'b1;
    cpu_sel   = 16'h0003;
    cpu_dat_m = wr_data;
    settle();
    check("wr_ack", cpu_ack, 1'b1);
    check("wr_stb", mem_stb, 1'b0);
    next();
    cpu_we    = 1'b0;
    cpu_sel   = 16'h0000;
    cpu_dat_m = '0;
    settle();
    check("rd_after_wr_ack", cpu_ack, 1'b1);
    check("rd_after_wr_dat", cpu_dat_s, line_a_mod);

    // ---- Conflict miss 0x018: writeback of dirty 0x010, then fill ----
    next();
    cpu_adr = 12'h018;
    settle();
    check("miss1_ack", cpu_ack, 1'b0);
    check("miss1_stb", mem_stb, 1'b0);
    next();
    settle();
    check_wb("wb1_c1", 12'h010, line_a_mod);
    next();
    mem_ack = 1'b1;
    settle();
    check_wb("wb1_c2", 12'h010, line_a_mod);
    next();
    mem_ack = 1'b0;
    settle();
    check_fill("fill1_c1", 12'h018);
    next();
    mem_ack   = 1'b1;
    mem_dat_s = LINE_B;
    settle();
    check_fill("fill1_c2", 12'h018);
    next();
    mem_ack   = 1'b0;
    mem_dat_s = JUNK;
    settle();
    check("hit2_ack", cpu_ack, 1'b1);
    check("hit2_dat", cpu_dat_s, LINE_B);
    check("hit2_stb", mem_stb, 1'b0);

    // ---- Reset asserted mid-FILL (clean miss of 0x010) ----
    next();
    cpu_adr = 12'h010;
    settle();
    check("miss2_ack", cpu_ack, 1'b0);
    next();
    settle();
    check_fill("fill2_c1", 12'h010);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_stb", mem_stb, 1'b0);
    check("async_rst_cyc", mem_cyc, 1'b0);
    check("async_rst_ack", cpu_ack, 1'b0);
    check("async_rst_we",  mem_we,  1'b0);
    mem_ack   = 1'b1;
    mem_dat_s = JUNK;
    next();
    mem_ack = 1'b0;
    next();
    rst = 1'b0;
    settle();
    check("post_rst_miss_ack", cpu_ack, 1'b0);
    check("post_rst_miss_stb", mem_stb, 1'b0);

    // ---- Same miss, memory delays ack by 5 cycles ----
    next();
    for (int i = 0; i < 5; i++) begin
      settle();
      check_fill($sformatf("slow_c%0d", i), 12'h010);
      next();
    end
    mem_ack   = 1'b1;
    mem_dat_s = LINE_C;
    settle();
    check_fill("slow_ackcyc", 12'h010);
    next();
    mem_ack   = 1'b0;
    mem_dat_s = JUNK;
    settle();
    check("hit3_ack", cpu_ack, 1'b1);
    check("hit3_dat", cpu_dat_s, LINE_C);

    // ---- Stray mem_ack in IDLE with no request is ignored ----
    next();
    cpu_stb   = 1'b0;
    cpu_cyc   = 1'b0;
    mem_ack   = 1'b1;
    settle();
    check("stray_ack_cpu", cpu_ack, 1'b0);
    check("stray_ack_stb", mem_stb, 1'b0);
    next();
    mem_ack = 1'b0;
    cpu_stb = 1'b1;
    cpu_cyc = 1'b1;
    settle();
    check("after_stray_hit", cpu_ack, 1'b1);
    check("after_stray_dat", cpu_dat_s, LINE_C);

    // ---- Request dropped mid-miss: fill of 0x020 still completes ----
    next();
    cpu_adr = 12'h020;
    settle();
    check("miss3_ack", cpu_ack, 1'b0);
    next();
    cpu_stb = 1'b0;
    cpu_cyc = 1'b0;
    cpu_adr = 12'h7FF;
    settle();
    check_fill("drop_fill", 12'h020);
    next();
    mem_ack   = 1'b1;
    mem_dat_s = LINE_D;
    next();
    mem_ack   = 1'b0;
    mem_dat_s = JUNK;
    settle();
    check("drop_idle_ack", cpu_ack, 1'b0);
    check("drop_idle_stb", mem_stb, 1'b0);
    next();
    cpu_adr = 12'h020;
    cpu_stb = 1'b1;
    cpu_cyc = 1'b1;
    settle();
    check("drop_rehit_ack", cpu_ack, 1'b1);
    check("drop_rehit_dat", cpu_dat_s, LINE_D);

    next();
    cpu_stb = 1'b0;
    cpu_cyc = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
